// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with ready/valid handshakes, count and almost_full.
// Define SYNC_FIFO_FLUSH_EN to add a synchronous flush input.
module sync_fifo #(
  parameter int dw = 8,
  parameter int depth = 16,
  parameter int af_level = depth - 2,
  localparam int aw = $clog2(depth)
) (
  input  logic          clock,
  input  logic          reset,
`ifdef SYNC_FIFO_FLUSH_EN
  input  logic          flush,
`endif
  input  logic [dw-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [dw-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [aw:0]   count,
  output logic          almost_full
);

  localparam logic [aw:0] FULL_C = (aw+1)'(depth);
  localparam logic [aw:0] AF_C = (aw+1)'(af_level);

  logic [dw-1:0] mem [depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          clr;

`ifdef SYNC_FIFO_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign in_ready    = (count != FULL_C);
  assign out_valid   = (count != '0);
  assign almost_full = (count >= AF_C);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_data    = mem[rd_ptr];

  // Storage is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (push && !reset && !clr)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model,
// directed scenarios and randomized traffic.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = DEPTH - 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [4:0]    count;
  logic          almost_full;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] q[$];

  sync_fifo #(.dw(DW), .depth(DEPTH), .af_level(AF)) dut (
    .clock(clock),
    .reset(reset),
`ifdef SYNC_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .almost_full(almost_full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    chk("in_ready", int'(in_ready), int'(q.size() != DEPTH));
    chk("count", int'(count), q.size());
    chk("almost_full", int'(almost_full), int'(q.size() >= AF));
    if (q.size() != 0)
      chk("out_data", int'(out_data), int'(q[0]));
  endtask

  task automatic model_update();
    bit can_push;
    bit can_pop;
    bit clr;
`ifdef SYNC_FIFO_FLUSH_EN
    clr = flush;
`else
    clr = 1'b0;
`endif
    if (reset || clr) begin
      q.delete();
    end else begin
      can_push = in_valid && (q.size() < DEPTH);
      can_pop  = out_ready && (q.size() > 0);
      if (can_pop)
        void'(q.pop_front());
      if (can_push)
        q.push_back(in_data);
    end
  endtask

  // Outputs are checked before each edge, after the inputs have settled.
  task automatic step();
    @(negedge clock);
    compare();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    idle();
    step();
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_almost_full", int'(almost_full), 0);

    // Reset in the middle of traffic with five entries held.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h30 + i);
      step();
    end
    chk("mid_count5", int'(count), 5);
    reset = 1'b1;
    in_data = 8'h77;
    step();
    idle();
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    step();

    // Fill 0x01..0x10, then try one extra write.
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i + 1);
      step();
      chk("fill_af", int'(almost_full), int'(i + 1 >= 14));
    end
    chk("full_count", int'(count), 16);
    chk("full_in_ready", int'(in_ready), 0);
    in_data = 8'hFF;
    step();
    chk("full_extra_count", int'(count), 16);
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", int'(out_data), i + 1);
      step();
    end
    chk("drained_valid", int'(out_valid), 0);
    idle();
    step();

    // A single word shows up one edge after it is written.
    in_valid = 1'b1;
    in_data = 8'hA5;
    #1;
    chk("a5_same_cycle", int'(out_valid), 0);
    step();
    idle();
    chk("a5_valid", int'(out_valid), 1);
    chk("a5_data", int'(out_data), 8'hA5);
    out_ready = 1'b1;
    step();
    idle();

    // Sustained push and pop with three entries resident.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h40 + i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 8'(8'h43 + i);
      step();
      chk("stream_count", int'(count), 3);
    end
    drain();

    // Full with both handshakes offered: only the pop happens.
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h80 + i);
      step();
    end
    in_data = 8'hEE;
    out_ready = 1'b1;
    step();
    chk("full_pop_count", int'(count), 15);
    in_valid = 1'b0;
    chk("full_pop_head", int'(out_data), 8'h81);
    drain();

    // Popping an empty FIFO does nothing.
    out_ready = 1'b1;
    step();
    step();
    chk("empty_pop_count", int'(count), 0);
    idle();

`ifdef SYNC_FIFO_FLUSH_EN
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h50 + i);
      step();
    end
    chk("flush_pre_count", int'(count), 7);
    flush = 1'b1;
    in_data = 8'hCC;
    step();
    idle();
    chk("flush_count", int'(count), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    step();
    chk("flush_no_store", int'(out_valid), 0);
    in_valid = 1'b1;
    in_data = 8'h11;
    step();
    reset = 1'b1;
    flush = 1'b1;
    step();
    idle();
    chk("rst_flush_count", int'(count), 0);
    chk("rst_flush_in_ready", int'(in_ready), 1);
`endif

    // Randomized traffic with rare resets (and flushes when present).
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(99) < 60);
      out_ready = ($urandom_range(99) < ((i / 500) % 2 ? 75 : 40));
      in_data = 8'($urandom);
      reset = ($urandom_range(299) == 0);
`ifdef SYNC_FIFO_FLUSH_EN
      flush = ($urandom_range(199) == 0);
`endif
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
